demod_arbiter: RTL and testbench
================================

DEMOD_ARBITER -- requirements
Module: demod_arbiter

Interface
REQ-001 Parameter C_S00_AXIS_TDATA_WIDTH, default 32, width of each IQ input beat ([15:0] I, [31:16] Q, signed).
REQ-002 Parameter C_M00_AXIS_TDATA_WIDTH, default 32, width of the output beat; SHALL equal C_S00_AXIS_TDATA_WIDTH.
REQ-003 Parameter BURST_LEN, default 16, maximum beats per grant; legal range 1..256.
REQ-004 s00_axis_aclk  input  1  sole clock; all logic on the rising edge.
REQ-005 s00_axis_areset  input  1  reset, synchronous, active-high.
REQ-006 s00_axis_tvalid/tready/tlast  in/out/in  1 each  channel-0 IQ stream handshake and burst end.
REQ-007 s00_axis_tdata  input  32  channel-0 IQ sample.
REQ-008 s01_axis_tvalid/tready/tlast  in/out/in  1 each  channel-1 IQ stream handshake and burst end.
REQ-009 s01_axis_tdata  input  32  channel-1 IQ sample.
REQ-010 m00_axis_tvalid/tready  out/in  1 each  shared demodulator input handshake.
REQ-011 m00_axis_tdata  output  32  granted sample, passed unmodified.
REQ-012 m00_axis_tlast  output  1  last beat of the current grant burst.
REQ-013 m00_axis_tuser  output  1  channel id of the beat (0 or 1); downstream demod uses it to select its previous-sample context.
REQ-014 m00_axis_tstrb  output  4  constant 4'hF.

Function
REQ-015 States: IDLE, GNT0, GNT1; exactly one state active; in IDLE both s0x tready SHALL be 0.
REQ-016 Output register "free" = !m00_axis_tvalid || m00_axis_tready; s00_axis_tready = (state==GNT0) && free; s01_axis_tready = (state==GNT1) && free; tready combinational, no dependence on s0x tvalid.
REQ-017 Accepted beat (tvalid && tready on granted channel) SHALL load m00 tdata, tuser = channel, tvalid = 1 on the next edge; latency exactly 1 cycle.
REQ-018 If free and no beat accepted, m00_axis_tvalid SHALL clear; while m00_axis_tvalid && !m00_axis_tready, m00 tdata/tuser/tlast SHALL hold stable.
REQ-019 Beat counter cnt, 8 bits, clears on grant, increments per accepted beat.
REQ-020 Burst end = accepted beat with cnt == BURST_LEN-1 OR input tlast == 1; that beat SHALL be output with m00_axis_tlast = 1, all other beats tlast = 0.
REQ-021 Pointer last_gnt records channel of the most recent grant.
REQ-022 IDLE: if only one channel tvalid, grant it; if both, grant channel != last_gnt; if none, stay IDLE; transition takes one cycle (no beat accepted in IDLE).
REQ-023 On burst end in GNTx: if other channel tvalid that cycle, go directly to its GNT state; else if channel x tvalid, re-grant GNTx with cnt cleared; else IDLE. No idle bubble on back-to-back bursts.
REQ-024 Grant SHALL NOT change mid-burst regardless of the other channel's tvalid; a granted channel deasserting tvalid holds the grant (no timeout).
REQ-025 Beats from different channels SHALL never be interleaved within one output burst; output order per channel equals input order.
REQ-026 Back-pressure: m00_axis_tready low stalls the granted channel without losing, duplicating or reordering beats.
REQ-027 BURST_LEN == 1: every beat is tlast=1 and arbitration alternates per beat when both channels request.

Reset
REQ-028 While s00_axis_areset = 1 at an edge: state = IDLE, last_gnt = 1 (channel 0 wins first tie), cnt = 0, m00_axis_tvalid = 0, m00_axis_tdata = 0, m00_axis_tlast = 0, m00_axis_tuser = 0.
REQ-029 Reset asserted mid-burst SHALL discard the pending output beat and grant; first post-reset grant follows REQ-022.

Verification
REQ-030 Both channels valid continuously, BURST_LEN=4, tready=1 -> output tuser 0,0,0,0,1,1,1,1,0... with tlast on every 4th beat, one beat per cycle after the first grant.
REQ-031 Only ch1 valid, data 0x00010001..0x00050005, BURST_LEN=16, ch1 tlast on 3rd beat -> 3 beats tuser=1, tlast on 0x00030003, re-grant ch1 without bubble, remaining 2 beats follow.
REQ-032 Streaming with m00_axis_tready toggled 1,0,0,1 pattern -> output sequence identical to tready=1 run; tdata stable during every stall cycle.
REQ-033 Ch0 granted, ch1 asserts tvalid at beat 2 of 16 -> ch0 keeps grant for all 16 beats; ch1 first beat appears the cycle after ch0 tlast beat.
REQ-034 Reset asserted at beat 5 of a ch1 burst -> next cycle m00_axis_tvalid=0, both tready=0; after release with both valid, ch0 granted first.
REQ-035 BURST_LEN=1, both valid -> tuser alternates 0,1,0,1, every beat tlast=1.

Source files
------------

// File: rtl/demod_arbiter_if.sv
// AXI4-Stream style bundle shared by the IQ inputs and the demodulator output of demod_arbiter.
interface demod_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic                    tuser;
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;

   modport master (output tvalid, tdata, tlast, tuser, tstrb, input tready);
   modport slave  (input tvalid, tdata, tlast, tuser, tstrb, output tready);
endinterface

// File: rtl/demod_arbiter.sv
// Two-channel IQ stream arbiter feeding one shared demodulator; bursts of up to BURST_LEN beats,
// round-robin between channels, channel id carried on tuser.
module demod_arbiter #(
   parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned BURST_LEN              = 16
) (
   input  logic           s00_axis_aclk,
   input  logic           s00_axis_areset,
   demod_arbiter_if.slave  s00_axis,
   demod_arbiter_if.slave  s01_axis,
   demod_arbiter_if.master m00_axis
);

   typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

   localparam logic [7:0] LastCnt = 8'(BURST_LEN - 1);

   state_e state_q, state_d;
   logic   last_gnt_q, last_gnt_d;
   logic   [7:0] cnt_q;

   logic                              tvalid_q, tlast_q, tuser_q;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q;
   logic [C_S00_AXIS_TDATA_WIDTH-1:0] in_data;

   logic free, acc_ch, acc, in_last, burst_end, grant;

   assign free      = !tvalid_q || m00_axis.tready;
   assign acc_ch    = (state_q == StGnt1);
   assign acc       = (s00_axis.tvalid && s00_axis.tready) || (s01_axis.tvalid && s01_axis.tready);
   assign in_last   = acc_ch ? s01_axis.tlast : s00_axis.tlast;
   assign in_data   = acc_ch ? s01_axis.tdata : s00_axis.tdata;
   assign burst_end = acc && ((cnt_q == LastCnt) || in_last);

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         state_q    <= StIdle;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            // last_gnt_q == 1 means channel 0 wins a tie
            if (s00_axis.tvalid && (!s01_axis.tvalid || last_gnt_q)) state_d = StGnt0;
            else if (s01_axis.tvalid)                                 state_d = StGnt1;
         end
         StGnt0: begin
            if (burst_end) begin
               if (s01_axis.tvalid)      state_d = StGnt1;
               else if (s00_axis.tvalid) state_d = StGnt0;
               else                      state_d = StIdle;
            end
         end
         StGnt1: begin
            if (burst_end) begin
               if (s00_axis.tvalid)      state_d = StGnt0;
               else if (s01_axis.tvalid) state_d = StGnt1;
               else                      state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      grant      = (state_d != StIdle) && ((state_q == StIdle) || burst_end);
      last_gnt_d = grant ? (state_d == StGnt1) : last_gnt_q;
   end

   always_comb begin
      s00_axis.tready = (state_q == StGnt0) && free;
      s01_axis.tready = (state_q == StGnt1) && free;
      m00_axis.tvalid = tvalid_q;
      m00_axis.tdata  = tdata_q;
      m00_axis.tlast  = tlast_q;
      m00_axis.tuser  = tuser_q;
      m00_axis.tstrb  = '1;
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         cnt_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
      end else begin
         if (grant)    cnt_q <= '0;
         else if (acc) cnt_q <= cnt_q + 8'd1;
         if (acc) begin
            tvalid_q <= 1'b1;
            tdata_q  <= in_data;
            tuser_q  <= acc_ch;
            tlast_q  <= burst_end;
         end else if (free) begin
            tvalid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_demod_arbiter.sv
// Bench for demod_arbiter: per-cycle vector table, directed corner sequences, and a randomized
// run checked by per-channel scoreboards.
module tb_demod_arbiter;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   demod_arbiter_if #(.DATA_WIDTH(32)) s0a ();
   demod_arbiter_if #(.DATA_WIDTH(32)) s1a ();
   demod_arbiter_if #(.DATA_WIDTH(32)) ma ();
   demod_arbiter_if #(.DATA_WIDTH(32)) s0b ();
   demod_arbiter_if #(.DATA_WIDTH(32)) s1b ();
   demod_arbiter_if #(.DATA_WIDTH(32)) mb ();

   demod_arbiter #(.BURST_LEN(4)) dut_a (
      .s00_axis_aclk  (clk),
      .s00_axis_areset(rst_a),
      .s00_axis       (s0a),
      .s01_axis       (s1a),
      .m00_axis       (ma)
   );

   demod_arbiter #(.BURST_LEN(1)) dut_b (
      .s00_axis_aclk  (clk),
      .s00_axis_areset(rst_b),
      .s00_axis       (s0b),
      .s01_axis       (s1b),
      .m00_axis       (mb)
   );

   typedef struct {
      logic v0, v1, l0, l1, mr;
      logic r0, r1, mv, mu, ml;
      logic [31:0] md;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        l;
      logic        u;
      int          cyc;
   } beat_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_a(input logic v0, v1, l0, l1, mr, input logic [31:0] d0, d1);
      s0a.tvalid = v0; s0a.tlast = l0; s0a.tdata = d0;
      s1a.tvalid = v1; s1a.tlast = l1; s1a.tdata = d1;
      ma.tready  = mr;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      set_a(0, 0, 0, 0, 1, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_a = 1'b0;
   endtask

   vec_t  tbl[18];
   beat_t outs[$];
   beat_t q0[$], q1[$];

   initial begin
      s0a.tuser = 0; s0a.tstrb = '1; s1a.tuser = 0; s1a.tstrb = '1;
      s0b.tuser = 0; s0b.tstrb = '1; s1b.tuser = 0; s1b.tstrb = '1;
      s0b.tvalid = 0; s0b.tlast = 0; s0b.tdata = 0;
      s1b.tvalid = 0; s1b.tlast = 0; s1b.tdata = 0;
      mb.tready = 1; rst_b = 1;

      //          v0 v1 l0 l1 mr  r0 r1 mv mu ml  md
      tbl[0]  = '{1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 32'h0};
      tbl[1]  = '{1, 1, 0, 0, 1,  1, 0, 0, 0, 0, 32'h0};
      tbl[2]  = '{1, 1, 0, 0, 1,  1, 0, 1, 0, 0, 32'h1};
      tbl[3]  = '{1, 1, 0, 0, 1,  1, 0, 1, 0, 0, 32'h2};
      tbl[4]  = '{1, 1, 0, 0, 1,  1, 0, 1, 0, 0, 32'h3};
      tbl[5]  = '{1, 1, 0, 0, 1,  0, 1, 1, 0, 1, 32'h4};
      tbl[6]  = '{1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 32'h10005};
      tbl[7]  = '{1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 32'h10005};
      tbl[8]  = '{1, 1, 0, 0, 1,  0, 1, 1, 1, 0, 32'h10005};
      tbl[9]  = '{1, 1, 0, 1, 1,  0, 1, 1, 1, 0, 32'h10008};
      tbl[10] = '{1, 0, 0, 0, 1,  1, 0, 1, 1, 1, 32'h10009};
      tbl[11] = '{0, 1, 0, 0, 1,  1, 0, 1, 0, 0, 32'hA};
      tbl[12] = '{0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 32'h0};
      tbl[13] = '{1, 1, 0, 0, 1,  1, 0, 0, 0, 0, 32'h0};
      tbl[14] = '{1, 1, 0, 0, 1,  1, 0, 1, 0, 0, 32'hD};
      tbl[15] = '{1, 1, 0, 0, 1,  1, 0, 1, 0, 0, 32'hE};
      tbl[16] = '{0, 0, 0, 0, 1,  0, 1, 1, 0, 1, 32'hF};
      tbl[17] = '{0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 32'h0};

      // Directed per-cycle table, BURST_LEN = 4; data = row index (ch1 tagged 0x1_0000)
      reset_a();
      for (int i = 0; i < 18; i++) begin
         set_a(tbl[i].v0, tbl[i].v1, tbl[i].l0, tbl[i].l1, tbl[i].mr,
               32'(i), 32'h0001_0000 | 32'(i));
         #1;
         if (i == 0) begin
            check("reset_tdata", ma.tdata, 0);
            check("reset_tlast", ma.tlast, 0);
            check("reset_tuser", ma.tuser, 0);
            check("tstrb", ma.tstrb, 4'hF);
         end
         check($sformatf("tbl%0d_s00_tready", i), s0a.tready, tbl[i].r0);
         check($sformatf("tbl%0d_s01_tready", i), s1a.tready, tbl[i].r1);
         check($sformatf("tbl%0d_tvalid", i), ma.tvalid, tbl[i].mv);
         if (tbl[i].mv) begin
            check($sformatf("tbl%0d_tdata", i), ma.tdata, tbl[i].md);
            check($sformatf("tbl%0d_tuser", i), ma.tuser, tbl[i].mu);
            check($sformatf("tbl%0d_tlast", i), ma.tlast, tbl[i].ml);
         end
         @(negedge clk);
      end

      // Channel 1 alone, input tlast on 3rd beat: re-grant without a bubble
      begin
         int idx = 0;
         reset_a();
         outs.delete();
         for (int c = 0; c < 12; c++) begin
            set_a(0, idx < 5, 0, idx == 2, 1, 0,
                  (idx < 5) ? 32'(32'h0001_0001 * (idx + 1)) : 32'h0);
            #1;
            if (ma.tvalid) outs.push_back('{ma.tdata, ma.tlast, ma.tuser, c});
            if (s1a.tvalid && s1a.tready) idx++;
            @(negedge clk);
         end
         check("ch1only_count", outs.size(), 5);
         if (outs.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
               check($sformatf("ch1only_data%0d", k), outs[k].d, 32'(32'h0001_0001 * (k + 1)));
               check($sformatf("ch1only_last%0d", k), outs[k].l, k == 2);
               check($sformatf("ch1only_user%0d", k), outs[k].u, 1);
               check($sformatf("ch1only_cycle%0d", k), outs[k].cyc, outs[0].cyc + k);
            end
         end
      end

      // Reset in the middle of a channel-1 burst
      begin
         int nacc = 0;
         reset_a();
         for (int c = 0; c < 10 && nacc < 3; c++) begin
            set_a(0, 1, 0, 0, 1, 0, 32'h5555_0000 | 32'(c));
            #1;
            if (s1a.tready) nacc++;
            @(negedge clk);
         end
         check("midrst_reached_beats", nacc, 3);
         rst_a = 1'b1;
         set_a(1, 1, 0, 0, 1, 32'h77, 32'h88);
         @(negedge clk);
         check("midrst_tvalid", ma.tvalid, 0);
         check("midrst_s00_tready", s0a.tready, 0);
         check("midrst_s01_tready", s1a.tready, 0);
         rst_a = 1'b0;
         #1;
         check("postrst_idle_s00", s0a.tready, 0);
         check("postrst_idle_s01", s1a.tready, 0);
         @(negedge clk);
         #1;
         check("postrst_first_gnt_s00", s0a.tready, 1);
         check("postrst_first_gnt_s01", s1a.tready, 0);
         @(negedge clk);
      end

      // BURST_LEN = 1: alternate every beat, every beat tlast
      begin
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst_b = 1'b0;
         outs.delete();
         for (int c = 0; c < 10; c++) begin
            s0b.tvalid = 1; s0b.tdata = 32'(c);
            s1b.tvalid = 1; s1b.tdata = 32'h100 | 32'(c);
            #1;
            if (mb.tvalid) outs.push_back('{mb.tdata, mb.tlast, mb.tuser, c});
            @(negedge clk);
         end
         check("bl1_count", outs.size(), 8);
         foreach (outs[k]) begin
            check($sformatf("bl1_user%0d", k), outs[k].u, k % 2);
            check($sformatf("bl1_last%0d", k), outs[k].l, 1);
            check($sformatf("bl1_data%0d", k), outs[k].d,
                  (k % 2) ? (32'h100 | 32'(k + 1)) : 32'(k + 1));
         end
      end

      // Randomized traffic against per-channel scoreboards
      begin
         logic        rv[2], rl[2], acc_p[2];
         logic [31:0] rd[2];
         logic        mr, stall_p, in_burst, burst_ch, exp_last, s_u, s_l;
         logic [31:0] s_d;
         int          bcnt;
         beat_t       b;
         rv = '{0, 0}; rl = '{0, 0}; acc_p = '{0, 0}; rd = '{0, 0};
         stall_p = 0; in_burst = 0; burst_ch = 0; bcnt = 0;
         s_u = 0; s_l = 0; s_d = 0;
         reset_a();
         for (int c = 0; c < 3200; c++) begin
            bit drain;
            drain = (c >= 3000);
            for (int ch = 0; ch < 2; ch++) begin
               if (!rv[ch] || acc_p[ch]) begin
                  rv[ch] = !drain && ($urandom_range(0, 2) != 0);
                  rd[ch] = $urandom;
                  rl[ch] = ($urandom_range(0, 5) == 0);
               end
            end
            mr = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            set_a(rv[0], rv[1], rl[0], rl[1], mr, rd[0], rd[1]);
            #1;
            if (s0a.tready && s1a.tready) check("rnd_tready_exclusive", 2, 1);
            if (stall_p) begin
               check("rnd_stall_tvalid", ma.tvalid, 1);
               check("rnd_stall_tdata", ma.tdata, s_d);
               check("rnd_stall_tuser", ma.tuser, s_u);
               check("rnd_stall_tlast", ma.tlast, s_l);
            end
            acc_p[0] = rv[0] && s0a.tready;
            acc_p[1] = rv[1] && s1a.tready;
            if (acc_p[0]) q0.push_back('{rd[0], rl[0], 1'b0, c});
            if (acc_p[1]) q1.push_back('{rd[1], rl[1], 1'b1, c});
            if (ma.tvalid && ma.tready) begin
               if ((ma.tuser ? q1.size() : q0.size()) == 0) begin
                  check("rnd_unexpected_beat", 0, 1);
               end else begin
                  b = ma.tuser ? q1.pop_front() : q0.pop_front();
                  check("rnd_tdata", ma.tdata, b.d);
                  if (in_burst) check("rnd_no_interleave", ma.tuser, burst_ch);
                  if (!in_burst) begin
                     in_burst = 1;
                     burst_ch = ma.tuser;
                     bcnt = 0;
                  end
                  bcnt++;
                  exp_last = b.l || (bcnt == 4);
                  check("rnd_tlast", ma.tlast, exp_last);
                  if (exp_last) in_burst = 0;
               end
            end
            stall_p = ma.tvalid && !ma.tready;
            s_d = ma.tdata; s_u = ma.tuser; s_l = ma.tlast;
            @(negedge clk);
         end
         check("rnd_q0_drained", q0.size(), 0);
         check("rnd_q1_drained", q1.size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
